datapath_seq: RTL and testbench

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/datapath_seq.sv | 122 ++++++++++++
 tb/tb_datapath_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq.sv
// Sequencer for a small A/B datapath: loads A, checks the A==5 flag, idles
// GAP_CYCLES cycles, loads B with a flag-dependent constant, strobes the
// output register and pulses done. Counts completed runs (saturating).
//
// Ports:
//   clock      - single clock, all state changes on posedge
//   reset_n    - asynchronous active-low reset
//   start      - request one sequence (ignored while busy)
//   abort      - cancel a running sequence, returns to IDLE on the next edge
//   Astatus    - datapath flag (A == 5), sampled when leaving CHECK
//   ALoad      - A-load strobe (LOAD_A)
//   BLoad      - B-load strobe (LOAD_B)
//   Muxsel     - B-constant select, 1 picks 8 and 0 picks 13 (LOAD_B only)
//   out_ctrl   - output-register strobe (OUT)
//   busy       - high whenever not IDLE
//   done       - one-cycle completion pulse (DONE)
//   a_match    - last Astatus value captured on leaving CHECK
//   run_count  - completed sequences, saturates at 255
module datapath_seq #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       Astatus,
  output logic       ALoad,
  output logic       BLoad,
  output logic       Muxsel,
  output logic       out_ctrl,
  output logic       busy,
  output logic       done,
  output logic       a_match,
  output logic [7:0] run_count
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StCheck,
    StGap,
    StLoadB,
    StOut,
    StDone
  } state_e;

  localparam bit         HasGap  = (GAP_CYCLES != 0);
  // Only meaningful when HasGap; the wrapped value for GAP_CYCLES == 0 is never compared.
  localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       a_match_q, a_match_d;
  logic [7:0] run_cnt_q, run_cnt_d;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      gap_cnt_q <= 4'd0;
      a_match_q <= 1'b0;
      run_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      a_match_q <= a_match_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Next-state logic; abort outranks every other transition outside IDLE.
  always_comb begin
    state_d = state_q;
    if (state_q != StIdle && abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (start && !abort) state_d = StLoadA;
        StLoadA: state_d = StCheck;
        StCheck: state_d = HasGap ? StGap : StLoadB;
        StGap:   if (gap_cnt_q == GapLast) state_d = StLoadB;
        StLoadB: state_d = StOut;
        StOut:   state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath-side registers
  always_comb begin
    // Counter is zero on every entry into GAP and counts only while staying there.
    gap_cnt_d = 4'd0;
    if (state_q == StGap && state_d == StGap) begin
      gap_cnt_d = gap_cnt_q + 4'd1;
    end

    // Capture only when CHECK completes; an abort in CHECK leaves the old value.
    a_match_d = a_match_q;
    if (state_q == StCheck && !abort) begin
      a_match_d = Astatus;
    end

    run_cnt_d = run_cnt_q;
    if (state_q == StDone && run_cnt_q != 8'hFF) begin
      run_cnt_d = run_cnt_q + 8'd1;
    end
  end

  // Moore output decode
  always_comb begin
    ALoad     = (state_q == StLoadA);
    BLoad     = (state_q == StLoadB);
    out_ctrl  = (state_q == StOut);
    done      = (state_q == StDone);
    busy      = (state_q != StIdle);
    Muxsel    = (state_q == StLoadB) ? a_match_q : 1'b0;
    a_match   = a_match_q;
    run_count = run_cnt_q;
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: two instances (GAP_CYCLES 2 and 0) share stimulus
// and are compared every cycle against a schedule-based reference model.
module tb_datapath_seq;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       Astatus;
  logic [1:0] aload;
  logic [1:0] bload;
  logic [1:0] muxsel;
  logic [1:0] outc;
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] amatch;
  logic [7:0] rcnt [2];

  int n_checks = 0;
  int n_bad    = 0;

  datapath_seq #(.GAP_CYCLES(2)) u_dut_g2 (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .Astatus   (Astatus),
    .ALoad     (aload[0]),
    .BLoad     (bload[0]),
    .Muxsel    (muxsel[0]),
    .out_ctrl  (outc[0]),
    .busy      (busy[0]),
    .done      (done[0]),
    .a_match   (amatch[0]),
    .run_count (rcnt[0])
  );

  datapath_seq #(.GAP_CYCLES(0)) u_dut_g0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .Astatus   (Astatus),
    .ALoad     (aload[1]),
    .BLoad     (bload[1]),
    .Muxsel    (muxsel[1]),
    .out_ctrl  (outc[1]),
    .busy      (busy[1]),
    .done      (done[1]),
    .a_match   (amatch[1]),
    .run_count (rcnt[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a sequence is a schedule of cycle offsets after the
  // accepting edge: 1 A-load, 2 check, 3..2+G gap, 3+G B-load, 4+G out, 5+G done.
  int gap_m [2] = '{2, 0};
  bit act_m [2];
  int ph_m  [2];
  bit am_m  [2];
  int rc_m  [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      act_m[i] = 1'b0;
      ph_m[i]  = 0;
      am_m[i]  = 1'b0;
      rc_m[i]  = 0;
    end
  endfunction

  function automatic void model_step(input bit st, input bit ab, input bit as);
    for (int i = 0; i < 2; i++) begin
      if (!act_m[i]) begin
        if (st && !ab) begin
          act_m[i] = 1'b1;
          ph_m[i]  = 1;
        end
      end else if (ab) begin
        act_m[i] = 1'b0;
      end else begin
        if (ph_m[i] == 2) am_m[i] = as;
        if (ph_m[i] == 5 + gap_m[i]) begin
          act_m[i] = 1'b0;
          if (rc_m[i] < 255) rc_m[i] = rc_m[i] + 1;
        end else begin
          ph_m[i] = ph_m[i] + 1;
        end
      end
    end
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int  g;
      bit  e_b;
      g   = gap_m[i];
      e_b = act_m[i] && ph_m[i] == 3 + g;
      check_eq($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(act_m[i]));
      check_eq($sformatf("aload[%0d]", i), 32'(aload[i]), 32'(act_m[i] && ph_m[i] == 1));
      check_eq($sformatf("bload[%0d]", i), 32'(bload[i]), 32'(e_b));
      check_eq($sformatf("outc[%0d]", i), 32'(outc[i]), 32'(act_m[i] && ph_m[i] == 4 + g));
      check_eq($sformatf("done[%0d]", i), 32'(done[i]), 32'(act_m[i] && ph_m[i] == 5 + g));
      check_eq($sformatf("muxsel[%0d]", i), 32'(muxsel[i]), 32'(e_b && am_m[i]));
      check_eq($sformatf("amatch[%0d]", i), 32'(amatch[i]), 32'(am_m[i]));
      check_eq($sformatf("rcnt[%0d]", i), 32'(rcnt[i]), 32'(rc_m[i]));
      check_eq($sformatf("onehot[%0d]", i),
               32'(int'(aload[i]) + int'(bload[i]) + int'(outc[i]) <= 1), 32'd1);
    end
  endtask

  task automatic cycle(input bit st, input bit ab, input bit as);
    start   = st;
    abort   = ab;
    Astatus = as;
    @(posedge clock);
    model_step(st, ab, as);
    #2;
    check_outputs();
  endtask

  task automatic apply_reset();
    start   = 1'b0;
    abort   = 1'b0;
    Astatus = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  // Abort is kept away from CHECK and DONE, where the intended capture/count
  // behaviour is not pinned down; it is exercised everywhere else.
  function automatic bit abort_ok();
    for (int i = 0; i < 2; i++) begin
      if (act_m[i] && (ph_m[i] == 2 || ph_m[i] == 5 + gap_m[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    Astatus = 1'b0;
    apply_reset();

    // Nominal run, Astatus=1 held.
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("nom_aload_c1", 32'(aload[0]), 32'd1);
    for (int t = 2; t <= 9; t++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (t == 5) begin
        check_eq("nom_bload_c5", 32'(bload[0]), 32'd1);
        check_eq("nom_mux_c5", 32'(muxsel[0]), 32'd1);
        check_eq("g0_done_c5", 32'(done[1]), 32'd1);
      end
      if (t == 6) check_eq("nom_out_c6", 32'(outc[0]), 32'd1);
      if (t == 7) check_eq("nom_done_c7", 32'(done[0]), 32'd1);
    end
    check_eq("nom_rcnt", 32'(rcnt[0]), 32'd1);
    check_eq("nom_amatch", 32'(amatch[0]), 32'd1);

    // Astatus=0 during CHECK selects B=13.
    cycle(1'b1, 1'b0, 1'b0);
    for (int t = 2; t <= 9; t++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (t == 5) check_eq("a0_mux_c5", 32'(muxsel[0]), 32'd0);
    end
    check_eq("a0_amatch", 32'(amatch[0]), 32'd0);

    // Abort during GAP (G=2 instance is in GAP at cycle 3).
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check_eq("abort_busy", 32'(busy[0]), 32'd0);
    for (int t = 0; t < 8; t++) cycle(1'b0, 1'b0, 1'b0);
    check_eq("abort_rcnt", 32'(rcnt[0]), 32'd2);

    // start and abort together in IDLE stay idle.
    for (int t = 0; t < 3; t++) cycle(1'b1, 1'b1, 1'b1);
    check_eq("sa_idle_busy", 32'(busy[0]), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      bit ab;
      ab = ($urandom_range(0, 15) == 0) && abort_ok();
      cycle(1'(($urandom_range(0, 3) != 0)), ab, 1'($urandom_range(0, 1)));
    end

    // Saturation with start held high.
    apply_reset();
    for (int n = 0; n < 2200; n++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    check_eq("sat_g2", 32'(rcnt[0]), 32'd255);
    check_eq("sat_g0", 32'(rcnt[1]), 32'd255);
    for (int n = 0; n < 10; n++) cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset while the G=2 instance is in OUT.
    cycle(1'b1, 1'b0, 1'b1);
    for (int t = 2; t <= 6; t++) cycle(1'b0, 1'b0, 1'b1);
    check_eq("pre_rst_out", 32'(outc[0]), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_out", 32'(outc[0]), 32'd0);
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_rcnt", 32'(rcnt[0]), 32'd0);
    check_eq("rst_amatch", 32'(amatch[0]), 32'd0);
    check_outputs();
    #1;
    reset_n = 1'b1;
    for (int t = 0; t < 12; t++) cycle(t == 1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
